// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronise, glitch-filter, deserialise and buffer device bytes.
// Optional key-event decoder on ps2_key is enabled by defining PS2_RX_KEYDECODE_EN.
module ps2_host_rx #(
    parameter int unsigned FIFO_BITS = 3,
    parameter int unsigned FILTER    = 8,
    parameter int unsigned TIMEOUT   = 20000
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rx_en,
    input  logic        rx_rd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        busy,
    output logic        parity_err,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        overflow
`ifdef PS2_RX_KEYDECODE_EN
    ,
    output logic [10:0] ps2_key
`endif
);

    localparam int unsigned Depth = 1 << FIFO_BITS;
    localparam int unsigned FW    = $clog2(FILTER + 1);
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FiltMax = FW'(FILTER - 1);
    localparam logic [TW-1:0] TimeMax = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d, filt_prev_q, fall;
    logic [FW-1:0]  fcnt_q, fcnt_d;

    state_e         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           par_q, par_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;
    logic           push_q, push_d;
    logic           perr_q, perr_d, ferr_q, ferr_d, terr_q, terr_d, ovf_q, ovf_d;

    logic [7:0]           mem_q [Depth];
    logic [FIFO_BITS-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [FIFO_BITS:0]   cnt_q, cnt_d;
    logic                 pop, accept;

    assign fall = filt_prev_q & ~filt_q;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FiltMax) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        push_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        terr_d    = 1'b0;
        tcnt_d    = (state_q == StIdle || fall) ? '0 : tcnt_q + 1'b1;
        if (!rx_en) begin
            state_d = StIdle;
        end else if (state_q != StIdle && tcnt_q == TimeMax) begin
            state_d = StIdle;
            terr_d  = 1'b1;
        end else if (fall) begin
            unique case (state_q)
                StIdle: begin
                    if (!dat_s2_q) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shreg_d   = {dat_s2_q, shreg_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = dat_s2_q;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!dat_s2_q) begin
                        ferr_d = 1'b1;
                    end else if (~^{shreg_q, par_q}) begin
                        perr_d = 1'b1;
                    end else begin
                        push_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // shreg_q is stable in IDLE, so the push cycle can write it directly.
    assign pop    = rx_rd & rx_valid;
    assign accept = push_q & (~cnt_q[FIFO_BITS] | pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        ovf_d  = push_q & ~accept;
        if (accept) wptr_d = wptr_q + 1'b1;
        if (pop)    rptr_d = rptr_q + 1'b1;
        unique case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            tcnt_q      <= '0;
            push_q      <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            terr_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            tcnt_q      <= tcnt_d;
            push_q      <= push_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            terr_q      <= terr_d;
            ovf_q       <= ovf_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            if (accept) mem_q[wptr_q] <= shreg_q;
        end
    end

    assign rx_data     = mem_q[rptr_q];
    assign rx_valid    = (cnt_q != '0);
    assign busy        = (state_q != StIdle);
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign timeout_err = terr_q;
    assign overflow    = ovf_q;

`ifdef PS2_RX_KEYDECODE_EN
    logic        ext_q, ext_d, rel_q, rel_d;
    logic [10:0] key_q, key_d;

    // Decodes every good frame, including ones the full FIFO drops.
    always_comb begin
        ext_d = ext_q;
        rel_d = rel_q;
        key_d = key_q;
        if (push_q) begin
            if (shreg_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shreg_q == 8'hF0) begin
                rel_d = 1'b1;
            end else begin
                key_d = {~key_q[10], ~rel_q, ext_q, shreg_q};
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
            key_q <= '0;
        end else begin
            ext_q <= ext_d;
            rel_q <= rel_d;
            key_q <= key_d;
        end
    end

    assign ps2_key = key_q;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: table of whole frames plus timeout, overflow, glitch,
// rx_en and reset sequences; key decoder checks when PS2_RX_KEYDECODE_EN is defined.
`timescale 1ns/1ps
module tb_ps2_host_rx;

    localparam int HALF    = 20;
    localparam int TIMEOUT = 400;

    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_en = 1'b1;
    logic       rx_rd = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, busy, parity_err, frame_err, timeout_err, overflow;
`ifdef PS2_RX_KEYDECODE_EN
    logic [10:0] ps2_key;
`endif

    ps2_host_rx #(
        .FIFO_BITS (3),
        .FILTER    (8),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_en       (rx_en),
        .rx_rd       (rx_rd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overflow    (overflow)
`ifdef PS2_RX_KEYDECODE_EN
        ,
        .ps2_key     (ps2_key)
`endif
    );

    always #10 clk_sys = ~clk_sys;

    int n_chk = 0;
    int n_pass = 0;
    int perr_n = 0, ferr_n = 0, terr_n = 0, ovf_n = 0;
    int p0, f0, t0, o0;

    always @(posedge clk_sys) begin
        if (parity_err)  perr_n++;
        if (frame_err)   ferr_n++;
        if (timeout_err) terr_n++;
        if (overflow)    ovf_n++;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic       p;
        logic       stop;
        logic       exp_valid;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_sys);
    endtask

    task automatic snap();
        p0 = perr_n; f0 = ferr_n; t0 = terr_n; o0 = ovf_n;
    endtask

    // Bit 0 of bits goes first on the wire; each bit is a HALF-high, HALF-low clock period.
    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at,
                             input bit rd_on_push);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                wait_cyc(8); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(HALF - 11);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (rd_on_push && i == n - 1) begin
                int k;
                bit seen;
                seen = 1'b0;
                k = 0;
                while (k < HALF && !seen) begin
                    @(negedge clk_sys);
                    k++;
                    if (!busy) seen = 1'b1;
                end
                check("push_window", 32'(seen), 32'd1);
                rx_rd = 1'b1;
                @(negedge clk_sys);
                rx_rd = 1'b0;
                wait_cyc(HALF);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                              input int glitch_at, input bit rd_on_push);
        send_bits({stop, p, d, 1'b0}, 11, glitch_at, rd_on_push);
        wait_cyc(5);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, ~^d, 1'b1, -1, 1'b0);
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        @(negedge clk_sys);
        rx_rd = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_data"}, 32'(rx_data), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_errs"}, 32'({parity_err, frame_err, timeout_err, overflow}), 32'd0);
`ifdef PS2_RX_KEYDECODE_EN
        check({tag, "_key"}, 32'(ps2_key), 32'd0);
`endif
    endtask

    initial begin
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        wait_cyc(4);
        check_all_zero("reset");
        rst_n = 1'b1;
        wait_cyc(4);

`ifdef PS2_RX_KEYDECODE_EN
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check("key_ext_rel", 32'(ps2_key), 32'({1'b1, 1'b0, 1'b1, 8'h75}));
        pop(); pop(); pop();
        send_good(8'h1C);
        check("key_plain", 32'(ps2_key), 32'({1'b0, 1'b1, 1'b0, 8'h1C}));
        pop();
        check("key_fifo_empty", 32'(rx_valid), 32'd0);
`endif

        foreach (vecs[i]) begin
            snap();
            send_frame(vecs[i].d, vecs[i].p, vecs[i].stop, -1, 1'b0);
            check($sformatf("vec%0d_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_perr", i), 32'(perr_n - p0), 32'(vecs[i].exp_perr));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_n - f0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_data", i), 32'(rx_data), 32'(vecs[i].d));
                pop();
                check($sformatf("vec%0d_popped", i), 32'(rx_valid), 32'd0);
            end
        end

        // Partial frame then silence.
        snap();
        send_bits(11'b0, 5, -1, 1'b0);
        check("to_busy_mid", 32'(busy), 32'd1);
        wait_cyc(TIMEOUT + 20);
        check("to_pulse", 32'(terr_n - t0), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_valid", 32'(rx_valid), 32'd0);
        send_good(8'h29);
        check("to_next_data", 32'(rx_data), 32'h29);
        check("to_next_valid", 32'(rx_valid), 32'd1);
        pop();

        // rx_en low drops the partial frame silently.
        snap();
        send_bits(11'b0, 4, -1, 1'b0);
        rx_en = 1'b0;
        wait_cyc(2);
        check("en_busy", 32'(busy), 32'd0);
        rx_en = 1'b1;
        wait_cyc(TIMEOUT + 20);
        check("en_noerr", 32'(terr_n - t0 + perr_n - p0 + ferr_n - f0), 32'd0);

        // Overflow: ninth byte dropped.
        snap();
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        check("ovf_none_8", 32'(ovf_n - o0), 32'd0);
        send_good(8'h09);
        check("ovf_on_9", 32'(ovf_n - o0), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovf_rd%0d", i), 32'(rx_data), 32'(i));
            pop();
        end
        check("ovf_empty", 32'(rx_valid), 32'd0);

        // Simultaneous pop lets the ninth byte in.
        snap();
        for (int i = 1; i <= 8; i++) send_good(8'(i));
        send_frame(8'h09, ~^8'h09, 1'b1, -1, 1'b1);
        check("ovf2_none", 32'(ovf_n - o0), 32'd0);
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("ovf2_rd%0d", i), 32'(rx_data), 32'(i));
            pop();
        end
        check("ovf2_empty", 32'(rx_valid), 32'd0);

        // Short clock glitches in IDLE and mid-frame.
        snap();
        ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(20);
        check("gl_idle_busy", 32'(busy), 32'd0);
        send_frame(8'hA5, 1'b1, 1'b1, 5, 1'b0);
        check("gl_valid", 32'(rx_valid), 32'd1);
        check("gl_data", 32'(rx_data), 32'hA5);
        check("gl_noerr", 32'(perr_n - p0 + ferr_n - f0 + terr_n - t0), 32'd0);
        pop();

        // Reset in the middle of a frame.
        send_good(8'h33);
        send_bits(11'b0, 6, -1, 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        wait_cyc(3);
        snap();
        send_good(8'h1C);
        check("rst_next_valid", 32'(rx_valid), 32'd1);
        check("rst_next_data", 32'(rx_data), 32'h1C);
        check("rst_next_noerr", 32'(perr_n - p0 + ferr_n - f0 + terr_n - t0), 32'd0);
        pop();
        check("rst_next_empty", 32'(rx_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
